imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 210 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte-stream handshake and instruction-memory write bus of the boot loader.
//   master : loader side (consumes bytes, drives memory writes)
//   slave  : environment side (produces bytes, observes memory writes)
//   i_byteValid / i_byteData / o_byteReady : valid/ready byte stream
//   o_wrEnable / o_wrAddress / o_wrData    : one-cycle instruction-memory write
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              i_byteValid;
  logic [7:0]        i_byteData;
  logic              o_byteReady;
  logic              o_wrEnable;
  logic [ADDR_W-1:0] o_wrAddress;
  logic [31:0]       o_wrData;

  modport master (
    input  i_byteValid, i_byteData,
    output o_byteReady, o_wrEnable, o_wrAddress, o_wrData
  );

  modport slave (
    output i_byteValid, i_byteData,
    input  o_byteReady, o_wrEnable, o_wrAddress, o_wrData
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction loader. Receives a 4-byte little-endian word count N
//   followed by N little-endian payload words over a valid/ready byte stream,
//   writes each word to instruction memory at byte address 4*index, and keeps
//   the core in synchronous reset until the image is complete.
//
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//     When defined, one extra byte follows the payload and must equal the XOR
//     of all payload bytes; a mismatch ends in ERROR with the core held.
//
// Ports
//   i_clk, i_arstn : clock, asynchronous active-low reset
//   i_start        : one-cycle pulse, starts a load from IDLE/DONE/ERROR
//   bus            : imem_loader_if.master (byte stream in, memory write out)
//   o_coreSrst     : synchronous reset to the core, low only in DONE
//   o_done         : image loaded
//   o_error        : load aborted (count too large or checksum mismatch)
module imem_loader #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic          i_clk,
  input  logic          i_arstn,
  input  logic          i_start,
  imem_loader_if.master bus,
  output logic          o_coreSrst,
  output logic          o_done,
  output logic          o_error
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic              ready_q, ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              core_srst_q, core_srst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept;
  logic [31:0]       nxt_word;
  logic [CNT_W-1:0]  word_idx_inc;

  // ready is registered, so acceptance depends only on flop state
  assign accept       = bus.i_byteValid && ready_q;
  // New byte enters the top; after four shifts byte 0 sits in [7:0]
  assign nxt_word     = {bus.i_byteData, shreg_q[31:8]};
  assign word_idx_inc = word_idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    word_cnt_d = word_cnt_q;
    word_idx_d = word_idx_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          state_d    = S_HEADER;
          byte_idx_d = '0;
          shreg_d    = '0;
          word_cnt_d = '0;
          word_idx_d = '0;
          wr_addr_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end

      S_HEADER: begin
        if (accept) begin
          shreg_d    = nxt_word;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            if (nxt_word == '0) begin
              state_d = S_DONE;
            end else if (nxt_word > 32'(MAX_WORDS)) begin
              state_d = S_ERROR;
            end else begin
              state_d    = S_PAYLOAD;
              // Safe truncation: nxt_word <= MAX_WORDS here
              word_cnt_d = CNT_W'(nxt_word);
            end
          end
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          shreg_d    = nxt_word;
          byte_idx_d = byte_idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ bus.i_byteData;
`endif
          if (byte_idx_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_data_d  = nxt_word;
            wr_addr_d  = ADDR_W'({word_idx_q, 2'b00});
            word_idx_d = word_idx_inc;
            if (word_idx_inc == word_cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          state_d = (bus.i_byteData == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // Registered status: ready follows the next state; done/error assert only
  // once the state register already holds DONE/ERROR (the cycle after entry)
  // and drop on the same edge that a restart leaves those states.
  always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_d = (state_d == S_HEADER) || (state_d == S_PAYLOAD) ||
              (state_d == S_CHECK);
`else
    ready_d = (state_d == S_HEADER) || (state_d == S_PAYLOAD);
`endif
    done_d      = (state_q == S_DONE)  && (state_d == S_DONE);
    error_d     = (state_q == S_ERROR) && (state_d == S_ERROR);
    core_srst_d = !done_d;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q     <= S_IDLE;
      byte_idx_q  <= '0;
      shreg_q     <= '0;
      word_cnt_q  <= '0;
      word_idx_q  <= '0;
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      core_srst_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      shreg_q     <= shreg_d;
      word_cnt_q  <= word_cnt_d;
      word_idx_q  <= word_idx_d;
      ready_q     <= ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      core_srst_q <= core_srst_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.o_byteReady = ready_q;
  assign bus.o_wrEnable  = wr_en_q;
  assign bus.o_wrAddress = wr_addr_q;
  assign bus.o_wrData    = wr_data_q;
  assign o_coreSrst      = core_srst_q;
  assign o_done          = done_q;
  assign o_error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, empty image, oversize count,
// gapped valid, mid-load async reset, and (when enabled) checksum pass/fail.
module tb_imem_loader;
  localparam int MAX_WORDS = 64;
  localparam int ADDR_W    = 32;

  logic i_clk   = 1'b0;
  logic i_arstn = 1'b0;
  logic i_start = 1'b0;
  logic o_coreSrst, o_done, o_error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .i_clk      (i_clk),
    .i_arstn    (i_arstn),
    .i_start    (i_start),
    .bus        (bus),
    .o_coreSrst (o_coreSrst),
    .o_done     (o_done),
    .o_error    (o_error)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int c0;
  logic [63:0] wlog[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  // One entry per strobe cycle: a strobe held two cycles logs twice
  always @(negedge i_clk)
    if (bus.o_wrEnable === 1'b1) wlog.push_back({bus.o_wrAddress, bus.o_wrData});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Present a byte after 'gap' idle cycles and hold it until accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   t;
    logic rdy;
    bus.i_byteValid = 1'b0;
    repeat (gap) step();
    bus.i_byteValid = 1'b1;
    bus.i_byteData  = b;
    t = 0;
    do begin
      rdy = bus.o_byteReady;
      step();
      t++;
    end while (!rdy && t < 20);
    check("byte_taken", {31'b0, rdy}, 32'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] addr,
                             input logic [31:0] data);
    logic [63:0] e;
    e = (idx < wlog.size()) ? wlog[idx] : 64'hxxxx_xxxx_xxxx_xxxx;
    check({tag, "_addr"}, e[63:32], addr);
    check({tag, "_data"}, e[31:0], data);
  endtask

  initial begin
    bus.i_byteValid = 1'b0;
    bus.i_byteData  = 8'h00;

    // ---- reset state ----
    #12;
    check("rst_ready",  {31'b0, bus.o_byteReady}, 32'd0);
    check("rst_wren",   {31'b0, bus.o_wrEnable},  32'd0);
    check("rst_addr",   bus.o_wrAddress,          32'd0);
    check("rst_data",   bus.o_wrData,             32'd0);
    check("rst_srst",   {31'b0, o_coreSrst},      32'd1);
    check("rst_done",   {31'b0, o_done},          32'd0);
    check("rst_error",  {31'b0, o_error},         32'd0);
    step();
    i_arstn = 1'b1;
    step();
    check("idle_ready", {31'b0, bus.o_byteReady}, 32'd0);

    // ---- two-word load, byte every cycle ----
    pulse_start();
    check("t1_ready", {31'b0, bus.o_byteReady}, 32'd1);
    c0 = cyc;
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("t1_srst_mid", {31'b0, o_coreSrst}, 32'd1);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    bus.i_byteValid = 1'b0;
    check("t1_no_bubble", cyc - c0, 32'd12);
    check("t1_wren",  {31'b0, bus.o_wrEnable}, 32'd1);
    check("t1_addr",  bus.o_wrAddress, 32'h4);
    check("t1_data",  bus.o_wrData,    32'h0010_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h90, 0);
    bus.i_byteValid = 1'b0;
`endif
    check("t1_done_early", {31'b0, o_done}, 32'd0);
    step();
    check("t1_done",  {31'b0, o_done},          32'd1);
    check("t1_srst",  {31'b0, o_coreSrst},      32'd0);
    check("t1_wren0", {31'b0, bus.o_wrEnable},  32'd0);
    check("t1_nwr",   wlog.size(), 32'd2);
    check_write("t1_w0", 0, 32'h0, 32'h0000_0013);
    check_write("t1_w1", 1, 32'h4, 32'h0010_0093);
    wlog.delete();

    // ---- empty image, restart from DONE ----
    pulse_start();
    check("t2_done_clr", {31'b0, o_done},     32'd0);
    check("t2_srst_set", {31'b0, o_coreSrst}, 32'd1);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    bus.i_byteValid = 1'b0;
    step();
    check("t2_done", {31'b0, o_done},     32'd1);
    check("t2_srst", {31'b0, o_coreSrst}, 32'd0);
    check("t2_nwr",  wlog.size(), 32'd0);

    // ---- count MAX_WORDS+1 rejected ----
    pulse_start();
    send_byte(8'h41, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("t3_ready", {31'b0, bus.o_byteReady}, 32'd0);
    bus.i_byteData = 8'h55;
    step();
    check("t3_error", {31'b0, o_error},    32'd1);
    check("t3_srst",  {31'b0, o_coreSrst}, 32'd1);
    check("t3_done",  {31'b0, o_done},     32'd0);
    step(); step();
    bus.i_byteValid = 1'b0;
    check("t3_ready2", {31'b0, bus.o_byteReady}, 32'd0);
    check("t3_nwr",    wlog.size(), 32'd0);

    // ---- one word with gaps in valid, restart from ERROR ----
    pulse_start();
    check("t4_err_clr", {31'b0, o_error}, 32'd0);
    send_byte(8'h01, 1); send_byte(8'h00, 0); send_byte(8'h00, 2); send_byte(8'h00, 0);
    send_byte(8'hAA, 2); send_byte(8'hBB, 1); send_byte(8'hCC, 0); send_byte(8'hDD, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1);
`endif
    bus.i_byteValid = 1'b0;
    step();
    check("t4_done", {31'b0, o_done}, 32'd1);
    check("t4_nwr",  wlog.size(), 32'd1);
    check_write("t4_w0", 0, 32'h0, 32'hDDCC_BBAA);
    wlog.delete();

    // ---- async reset mid-payload, then clean reload ----
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    bus.i_byteValid = 1'b0;
    #2;
    i_arstn = 1'b0;
    #1;
    check("t5_ready", {31'b0, bus.o_byteReady}, 32'd0);
    check("t5_addr",  bus.o_wrAddress,          32'd0);
    check("t5_data",  bus.o_wrData,             32'd0);
    check("t5_srst",  {31'b0, o_coreSrst},      32'd1);
    check("t5_done",  {31'b0, o_done},          32'd0);
    step(); step();
    i_arstn = 1'b1;
    step();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h88, 0);
`endif
    bus.i_byteValid = 1'b0;
    step();
    check("t5_done2", {31'b0, o_done}, 32'd1);
    check("t5_nwr",   wlog.size(), 32'd2);
    check_write("t5_w0", 0, 32'h0, 32'h4433_2211);
    check_write("t5_w1", 1, 32'h4, 32'h8877_6655);
    wlog.delete();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // ---- checksum match ----
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
    send_byte(8'h0F, 0);
    bus.i_byteValid = 1'b0;
    step();
    check("c1_done", {31'b0, o_done},  32'd1);
    check("c1_err",  {31'b0, o_error}, 32'd0);
    check_write("c1_w0", 0, 32'h0, 32'h0804_0201);
    wlog.delete();

    // ---- checksum mismatch ----
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
    send_byte(8'h0E, 0);
    bus.i_byteValid = 1'b0;
    step();
    check("c2_err",  {31'b0, o_error},    32'd1);
    check("c2_done", {31'b0, o_done},     32'd0);
    check("c2_srst", {31'b0, o_coreSrst}, 32'd1);
    check("c2_nwr",  wlog.size(), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
